// File: rtl/conf_int_mul_pkg.sv
// Shared constants and helpers for the configurable-precision MAC pipeline.
package conf_int_mul_pkg;

    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    localparam int OP_W      = 16;
    localparam int DP_W      = 24;
    localparam int OUT_W     = 32;
    localparam int SHIFT_DEF = 11;
    localparam int GUARD_DEF = 8;
    localparam int APX_W     = 5;

    // Limit the requested LSB mask so the accurate MSBs are never touched.
    function automatic logic [APX_W-1:0] clamp_apx(input logic [APX_W-1:0] apx_bits,
                                                   input int dw, input int op_w);
        int lim;
        lim = dw - op_w;
        if (int'(apx_bits) > lim) begin
            return APX_W'(lim);
        end
        return apx_bits;
    endfunction

    // Floor-shift then saturate to ow bits; returns {sat, p}. The result
    // vector is sized for OUT_W, so callers must use ow <= OUT_W.
    function automatic logic [OUT_W:0] sat_shift(input longint r, input int shift, input int ow);
        longint q;
        longint hi;
        longint lo;
        q  = r >>> shift;
        hi = (longint'(1) <<< (ow - 1)) - 1;
        lo = -hi - 1;
        if (q > hi) begin
            return {1'b1, OUT_W'(hi)};
        end
        if (q < lo) begin
            return {1'b1, OUT_W'(lo)};
        end
        return {1'b0, OUT_W'(q)};
    endfunction

endpackage

// File: rtl/conf_int_apx_mask.sv
// Zeroes the k least-significant bits of an operand (approximate mode).
module conf_int_apx_mask #(
    parameter int DW = 24
) (
    input  logic [DW-1:0] d,
    input  logic [4:0]    k,
    output logic [DW-1:0] q
);

    assign q = d & ({DW{1'b1}} << k);

endmodule

// File: rtl/conf_int_mac_pipe.sv
// Three-stage signed multiply / multiply-accumulate with optional LSB masking,
// floor scaling and output saturation. The whole pipe freezes while the
// output register holds a result the consumer has not taken.
module conf_int_mac_pipe
    import conf_int_mul_pkg::*;
#(
    parameter int OP_BITWIDTH        = OP_W,
    parameter int DATA_PATH_BITWIDTH = DP_W,
    parameter int OUT_BITWIDTH       = OUT_W,
    parameter int OUT_SHIFT          = SHIFT_DEF,
    parameter int ACC_GUARD          = GUARD_DEF
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    input  logic                          apx_en,
    input  logic [4:0]                    apx_bits,
    input  logic                          mode,
    input  logic                          acc_clr,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_BITWIDTH-1:0]       p,
    output logic                          p_sat
);

    localparam int DW = DATA_PATH_BITWIDTH;
    localparam int PW = 2 * DW;
    localparam int AW = PW + ACC_GUARD;
    localparam int OW = OUT_BITWIDTH;

    logic          stall;
    logic          accept;
    logic [4:0]    apx_k;
    logic [DW-1:0] a_m;
    logic [DW-1:0] b_m;

    logic                 s0_valid;
    logic signed [DW-1:0] s0_a;
    logic signed [DW-1:0] s0_b;
    logic                 s0_mode;
    logic                 s0_clr;
    logic                 s0_last;

    logic                 s1_valid;
    logic signed [PW-1:0] s1_prod;
    logic                 s1_mode;
    logic                 s1_clr;
    logic                 s1_last;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] acc_sum;
    logic signed [AW-1:0] r;
    logic [OUT_W:0]       sat_res;
    logic                 emit;

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && in_ready;
    assign apx_k    = apx_en ? clamp_apx(apx_bits, DW, OP_BITWIDTH) : '0;

    conf_int_apx_mask #(.DW(DW)) u_mask_a (.d(a), .k(apx_k), .q(a_m));
    conf_int_apx_mask #(.DW(DW)) u_mask_b (.d(b), .k(apx_k), .q(b_m));

    // S0: capture the (masked) operands and the beat's control bits.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s0_valid <= 1'b0;
            s0_a     <= '0;
            s0_b     <= '0;
            s0_mode  <= MODE_MUL;
            s0_clr   <= 1'b0;
            s0_last  <= 1'b0;
        end else if (!stall) begin
            s0_valid <= accept;
            if (accept) begin
                s0_a    <= a_m;
                s0_b    <= b_m;
                s0_mode <= mode;
                s0_clr  <= acc_clr;
                s0_last <= in_last;
            end
        end
    end

    // S1: full-width signed product.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_mode  <= MODE_MUL;
            s1_clr   <= 1'b0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= s0_valid;
            if (s0_valid) begin
                s1_prod <= PW'(s0_a) * PW'(s0_b);
                s1_mode <= s0_mode;
                s1_clr  <= s0_clr;
                s1_last <= s0_last;
            end
        end
    end

    // S2 datapath: pick the product or the updated accumulator, then scale/saturate.
    always_comb begin
        prod_ext = AW'(s1_prod);
        acc_sum  = (s1_clr ? '0 : acc) + prod_ext;
        r        = (s1_mode == MODE_ACC) ? acc_sum : prod_ext;
        sat_res  = sat_shift(longint'(r), OUT_SHIFT, OW);
        emit     = s1_valid && ((s1_mode == MODE_MUL) || s1_last);
    end

    // S2: accumulator update and the registered output.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            acc       <= '0;
            out_valid <= 1'b0;
            p         <= '0;
            p_sat     <= 1'b0;
        end else if (!stall) begin
            out_valid <= emit;
            if (s1_valid && (s1_mode == MODE_ACC)) begin
                acc <= acc_sum;
            end
            if (emit) begin
                p     <= sat_res[OW-1:0];
                p_sat <= sat_res[OUT_W];
            end
        end
    end

endmodule

// File: tb/tb_conf_int_mac_pipe.sv
// Bench for conf_int_mac_pipe: directed vector table, multi-cycle corner
// sequences and a randomized run against an arithmetic reference model.
module tb_conf_int_mac_pipe;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [23:0] a = '0;
    logic [23:0] b = '0;
    logic        apx_en = 1'b0;
    logic [4:0]  apx_bits = '0;
    logic        mode = 1'b0;
    logic        acc_clr = 1'b0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] p;
    logic        p_sat;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ov_count = 0;
    logic [31:0] last_p = '0;
    logic        last_sat = 1'b0;

    logic [31:0] exp_p_q[$];
    logic        exp_s_q[$];
    longint      m_acc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_p = '0;
    logic        prev_sat = 1'b0;
    logic        rand_done = 1'b0;

    typedef struct {
        logic [23:0] va;
        logic [23:0] vb;
        logic        en;
        logic [4:0]  bits;
        logic [31:0] ep;
        logic        es;
    } vec_t;
    vec_t vecs[13];

    conf_int_mac_pipe dut (
        .clk(clk), .rstN(rstN), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .apx_en(apx_en), .apx_bits(apx_bits), .mode(mode),
        .acc_clr(acc_clr), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .p(p), .p_sat(p_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Operand as seen by the multiplier: low k bits dropped, k capped at 8.
    function automatic longint masked(input logic [23:0] v, input logic en, input logic [4:0] bits);
        int k;
        longint s;
        k = en ? ((int'(bits) > 8) ? 8 : int'(bits)) : 0;
        s = longint'($signed(v));
        return (s >>> k) <<< k;
    endfunction

    function automatic logic [32:0] sat_model(input longint r);
        longint q;
        q = r >>> 11;
        if (q > 64'sd2147483647) return {1'b1, 32'h7FFFFFFF};
        if (q < -64'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, q[31:0]};
    endfunction

    function automatic logic [23:0] rnd_op();
        case ($urandom_range(0, 3))
            0: return 24'($urandom);
            1: return 24'(int'($urandom_range(0, 8191)) - 4096);
            2: return ($urandom_range(0, 1) != 0) ? 24'h7FFFFF : 24'h800000;
            default: return 24'($urandom);
        endcase
    endfunction

    // Monitor / scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        longint prod;
        logic [32:0] e;
        if (!rstN) begin
            exp_p_q.delete();
            exp_s_q.delete();
            m_acc = 0;
            prev_stall = 1'b0;
        end else begin
            check("in_ready_rule", in_ready, !(out_valid && !out_ready));
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_p", p, prev_p);
                check("hold_sat", p_sat, prev_sat);
            end
            if (out_valid && out_ready) begin
                if (exp_p_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result got p=%0h expected no result", p);
                end else begin
                    check("sb_p", p, exp_p_q.pop_front());
                    check("sb_sat", p_sat, exp_s_q.pop_front());
                end
                ov_count++;
                last_p = p;
                last_sat = p_sat;
            end
            if (in_valid && in_ready) begin
                prod = masked(a, apx_en, apx_bits) * masked(b, apx_en, apx_bits);
                if (mode == 1'b0) begin
                    e = sat_model(prod);
                    exp_p_q.push_back(e[31:0]);
                    exp_s_q.push_back(e[32]);
                end else begin
                    m_acc = (acc_clr ? 0 : m_acc) + prod;
                    m_acc = (m_acc <<< 8) >>> 8;
                    if (in_last) begin
                        e = sat_model(m_acc);
                        exp_p_q.push_back(e[31:0]);
                        exp_s_q.push_back(e[32]);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_p = p;
            prev_sat = p_sat;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input logic [23:0] ta, input logic [23:0] tb, input logic ten,
                        input logic [4:0] tbits, input logic tmode, input logic tclr,
                        input logic tlast, output int acc_cyc);
        logic ok;
        int c;
        a = ta; b = tb; apx_en = ten; apx_bits = tbits;
        mode = tmode; acc_clr = tclr; in_last = tlast; in_valid = 1'b1;
        acc_cyc = -1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            ok = in_ready;
            c = cyc;
            @(posedge clk);
            #1;
            if (ok) begin
                acc_cyc = c;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got in_ready=0 for 200 cycles expected acceptance");
        end
    endtask

    task automatic wait_out(output int seen_cyc);
        seen_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen_cyc = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_out_timeout got out_valid=0 for 20 cycles expected a result");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ac;
        int sc;
        int base;
        int low_cnt;

        vecs[0]  = '{24'h000800, 24'h000400, 1'b0, 5'd0,  32'h00000400, 1'b0};
        vecs[1]  = '{24'h0001FF, 24'h000100, 1'b1, 5'd8,  32'h00000020, 1'b0};
        vecs[2]  = '{24'h0001FF, 24'h000100, 1'b1, 5'd31, 32'h00000020, 1'b0};
        vecs[3]  = '{24'h0001FF, 24'h000100, 1'b0, 5'd8,  32'h0000003F, 1'b0};
        vecs[4]  = '{24'hFFF800, 24'h000400, 1'b0, 5'd0,  32'hFFFFFC00, 1'b0};
        vecs[5]  = '{24'h7FFFFF, 24'h7FFFFF, 1'b0, 5'd0,  32'h7FFFFFFF, 1'b1};
        vecs[6]  = '{24'h800000, 24'h7FFFFF, 1'b0, 5'd0,  32'h80000000, 1'b1};
        vecs[7]  = '{24'h400000, 24'h100000, 1'b0, 5'd0,  32'h7FFFFFFF, 1'b1};
        vecs[8]  = '{24'h400000, 24'hF00000, 1'b0, 5'd0,  32'h80000000, 1'b0};
        vecs[9]  = '{24'hFFFFFF, 24'h000001, 1'b0, 5'd0,  32'hFFFFFFFF, 1'b0};
        vecs[10] = '{24'hFFFFFF, 24'h000800, 1'b1, 5'd4,  32'hFFFFFFF0, 1'b0};
        vecs[11] = '{24'h000001, 24'h0007FF, 1'b0, 5'd0,  32'h00000000, 1'b0};
        vecs[12] = '{24'h00000F, 24'h000800, 1'b1, 5'd3,  32'h00000008, 1'b0};

        rstN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_p", p, 0);
        check("reset_p_sat", p_sat, 0);
        rstN = 1'b1;
        #1;
        check("ready_after_reset", in_ready, 1);
        @(posedge clk);
        #1;

        // Single-product vectors, one at a time.
        for (int i = 0; i < 13; i++) begin
            send(vecs[i].va, vecs[i].vb, vecs[i].en, vecs[i].bits, 1'b0, 1'b0, 1'b0, ac);
            wait_out(sc);
            if (i == 0) check("latency_cycles", sc - ac, 3);
            check($sformatf("vec%0d_p", i), p, vecs[i].ep);
            check($sformatf("vec%0d_sat", i), p_sat, vecs[i].es);
            @(posedge clk);
            #1;
        end

        // Accumulate group of four, then a fresh cleared group.
        base = ov_count;
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, ac);
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, ac);
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, ac);
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, ac);
        repeat (6) @(posedge clk);
        #1;
        check("acc4_count", ov_count - base, 1);
        check("acc4_p", last_p, 4096);
        base = ov_count;
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, ac);
        repeat (6) @(posedge clk);
        #1;
        check("acc_reclear_count", ov_count - base, 1);
        check("acc_reclear_p", last_p, 1024);

        // A product beat inside an accumulate group leaves the accumulator alone.
        base = ov_count;
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, ac);
        send(24'h001000, 24'h000400, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ac);
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, ac);
        repeat (6) @(posedge clk);
        #1;
        check("mix_count", ov_count - base, 2);
        check("mix_acc_p", last_p, 2048);

        // Backpressure: six back-to-back beats, consumer stalls for five cycles.
        base = ov_count;
        low_cnt = 0;
        out_ready = 1'b0;
        fork
            begin
                int acx;
                for (int i = 0; i < 6; i++)
                    send(24'((i + 1) * 2048), 24'h000400, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, acx);
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                for (int j = 0; j < 5; j++) begin
                    if (out_valid && !in_ready) low_cnt++;
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        check("bp_count", ov_count - base, 6);
        check("bp_ready_low_cycles", low_cnt, 5);
        check("bp_last_p", last_p, 6144);

        // Reset in the middle of an accumulate group with two beats in flight.
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, ac);
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, ac);
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, ac);
        #2;
        rstN = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_p", p, 0);
        check("midrst_p_sat", p_sat, 0);
        base = ov_count;
        repeat (2) @(posedge clk);
        #1;
        rstN = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("midrst_no_output", ov_count - base, 0);
        check("midrst_in_ready", in_ready, 1);
        send(24'h000800, 24'h000400, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, ac);
        repeat (6) @(posedge clk);
        #1;
        check("midrst_restart_count", ov_count - base, 1);
        check("midrst_restart_p", last_p, 1024);

        // Randomized mixed traffic with random consumer stalls.
        rand_done = 1'b0;
        fork
            begin
                int acr;
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                         1'($urandom_range(0, 2) == 0), acr);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("random_drain", exp_p_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
